// File: rtl/i2c_csr_bridge_if.sv
// i2c_csr_bridge_if: pad-side I2C lines and the internal CSR bus of the bridge.
//   scl, sda_in : I2C clock/data as seen on the pads
//   sda_oe      : 1 = pull SDA low (open drain)
//   csr_a/csr_di/csr_we : CSR address, write data, one-clk write strobe
//   csr_do      : CSR read data, valid one clk after csr_a changes
// master = bridge side, slave = pads + CSR decoder side.
interface i2c_csr_bridge_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          scl;
  logic          sda_in;
  logic          sda_oe;
  logic [AW-1:0] csr_a;
  logic [DW-1:0] csr_di;
  logic          csr_we;
  logic [DW-1:0] csr_do;

  modport master (
    input  scl, sda_in, csr_do,
    output sda_oe, csr_a, csr_di, csr_we
  );

  modport slave (
    output scl, sda_in, csr_do,
    input  sda_oe, csr_a, csr_di, csr_we
  );
endinterface

// File: rtl/i2c_csr_bridge.sv
// i2c_csr_bridge: I2C target that turns host transfers into CSR bus reads and
// writes through an auto-incrementing 5-bit register pointer.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : i2c_csr_bridge_if.master (scl, sda_in, sda_oe, csr_a, csr_di,
//              csr_we, csr_do)
// Optional SCL-low timeout: define I2C_CSR_TIMEOUT_EN (adds TIMEOUT_CYCLES).
module i2c_csr_bridge #(
  parameter logic [6:0]  I2C_ADDR   = 7'h4a,
  parameter int unsigned FILTER_LEN = 3
`ifdef I2C_CSR_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
`endif
) (
  input logic              clk,
  input logic              rst,
  i2c_csr_bridge_if.master bus
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned BCW = 4;
  localparam int unsigned PW  = 5;
  localparam int unsigned DW  = 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // Input path: bit 1 = SCL, bit 0 = SDA. Reset to the idle (high) bus level.
  logic [1:0]     sync1, sync2, filt, filt_d;
  logic [FCW-1:0] fcnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {bus.scl, bus.sda_in};
      sync2  <= sync1;
      filt_d <= filt;
      // Accept a new level only after FILTER_LEN consecutive differing samples
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  // Bus events on the filtered lines only
  always_comb begin
    scl_f     = filt[1];
    sda_f     = filt[0];
    scl_rise  = filt[1] & ~filt_d[1];
    scl_fall  = ~filt[1] & filt_d[1];
    start_det = filt[1] & filt_d[1] & filt_d[0] & ~filt[0];
    stop_det  = filt[1] & filt_d[1] & ~filt_d[0] & filt[0];
  end

  state_t          state, state_n;
  logic [DW-1:0]   sh, sh_n;
  logic [BCW-1:0]  bit_cnt, bit_cnt_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic            sda_oe_r, sda_oe_n;
  logic [DW-1:0]   csr_di_r, csr_di_n;
  logic            csr_we_r, csr_we_n;
  logic            rw, rw_n;
  logic            host_ack, host_ack_n;
  logic            wr_pend, wr_pend_n;   // strobe the received byte next clk
  logic            inc_pend, inc_pend_n; // bump pointer the clk after the strobe
`ifdef I2C_CSR_TIMEOUT_EN
  logic [15:0]     to_cnt, to_cnt_n;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      bit_cnt  <= '0;
      ptr      <= '0;
      sda_oe_r <= 1'b0;
      csr_di_r <= '0;
      csr_we_r <= 1'b0;
      rw       <= 1'b0;
      host_ack <= 1'b0;
      wr_pend  <= 1'b0;
      inc_pend <= 1'b0;
`ifdef I2C_CSR_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      bit_cnt  <= bit_cnt_n;
      ptr      <= ptr_n;
      sda_oe_r <= sda_oe_n;
      csr_di_r <= csr_di_n;
      csr_we_r <= csr_we_n;
      rw       <= rw_n;
      host_ack <= host_ack_n;
      wr_pend  <= wr_pend_n;
      inc_pend <= inc_pend_n;
`ifdef I2C_CSR_TIMEOUT_EN
      to_cnt   <= to_cnt_n;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    bit_cnt_n  = bit_cnt;
    ptr_n      = ptr;
    sda_oe_n   = sda_oe_r;
    csr_di_n   = csr_di_r;
    csr_we_n   = 1'b0;
    rw_n       = rw;
    host_ack_n = host_ack;
    wr_pend_n  = 1'b0;
    inc_pend_n = 1'b0;
`ifdef I2C_CSR_TIMEOUT_EN
    to_cnt_n   = '0;
`endif

    // Write strobe pipeline runs independently of later bus events
    if (wr_pend) begin
      csr_di_n   = sh;
      csr_we_n   = 1'b1;
      inc_pend_n = 1'b1;
    end
    if (inc_pend) begin
      ptr_n = ptr + PW'(1);
    end

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise && bit_cnt != BCW'(8)) begin
            sh_n      = {sh[6:0], sda_f};
            bit_cnt_n = bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(7)) begin
              if (state == REG)   ptr_n     = {sh[3:0], sda_f};
              if (state == WDATA) wr_pend_n = 1'b1;
            end
          end else if (scl_fall && bit_cnt == BCW'(8)) begin
            bit_cnt_n = '0;
            if (state == ADDR) begin
              if (sh[7:1] == I2C_ADDR) begin
                state_n  = ADDR_ACK;
                sda_oe_n = 1'b1;
                rw_n     = sh[0];
              end else begin
                state_n = IGNORE;
              end
            end else begin
              state_n  = (state == REG) ? REG_ACK : WDATA_ACK;
              sda_oe_n = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_n  = RDATA;
              sh_n     = bus.csr_do;
              sda_oe_n = ~bus.csr_do[7];
            end else begin
              state_n  = REG;
              sda_oe_n = 1'b0;
            end
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_n  = WDATA;
            sda_oe_n = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise && bit_cnt != BCW'(8)) begin
            bit_cnt_n = bit_cnt + BCW'(1);
          end else if (scl_fall) begin
            if (bit_cnt == BCW'(8)) begin
              // Release SDA so the host can drive its ACK/NACK
              state_n   = RDATA_ACK;
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
            end else begin
              sh_n     = {sh[6:0], 1'b0};
              sda_oe_n = ~sh[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            host_ack_n = ~sda_f;
            if (!sda_f) ptr_n = ptr + PW'(1);
          end else if (scl_fall) begin
            if (host_ack) begin
              state_n  = RDATA;
              sh_n     = bus.csr_do;
              sda_oe_n = ~bus.csr_do[7];
            end else begin
              state_n  = IGNORE;
              sda_oe_n = 1'b0;
            end
          end
        end
        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end

`ifdef I2C_CSR_TIMEOUT_EN
    // Abort a transfer whose SCL has been held low too long
    if (state != IDLE && state != IGNORE && !scl_f) begin
      to_cnt_n = to_cnt + 16'd1;
    end
    if (to_cnt_n == TIMEOUT_CYCLES) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
      wr_pend_n = 1'b0;
      to_cnt_n  = '0;
    end
`endif
  end

  assign bus.sda_oe = sda_oe_r;
  assign bus.csr_a  = ptr;
  assign bus.csr_di = csr_di_r;
  assign bus.csr_we = csr_we_r;

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// tb_i2c_csr_bridge: directed I2C host transfers against i2c_csr_bridge with
// a registered CSR read model (csr_do = 8'h10 + csr_a) and a write monitor.
module tb_i2c_csr_bridge;
  localparam int Q = 8; // clk cycles per quarter I2C bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_r = 1'b1;
  logic host_low = 1'b0;
  wire  sda_bus;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] we_a [$];
  logic [7:0] we_d [$];
  int         we_long = 0;
  logic       we_prev = 1'b0;
  logic       oe_seen = 1'b0;

  i2c_csr_bridge_if bus ();

`ifdef I2C_CSR_TIMEOUT_EN
  i2c_csr_bridge #(.I2C_ADDR(7'h4a), .FILTER_LEN(3), .TIMEOUT_CYCLES(16'd100)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`else
  i2c_csr_bridge #(.I2C_ADDR(7'h4a), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  assign sda_bus    = ~(host_low | bus.sda_oe);
  assign bus.sda_in = sda_bus;
  assign bus.scl    = scl_r;

  always @(posedge clk) bus.csr_do <= 8'h10 + {3'b000, bus.csr_a};

  always @(posedge clk) begin
    if (bus.csr_we) begin
      we_a.push_back(bus.csr_a);
      we_d.push_back(bus.csr_di);
    end
    if (bus.csr_we && we_prev) we_long = we_long + 1;
    we_prev = bus.csr_we;
    if (bus.sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (we_a.size() > i) ? {27'd0, we_a[i]} : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return (we_d.size() > i) ? {24'd0, we_d[i]} : 32'hxxxxxxxx;
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL period; gl puts a 1-clk SDA glitch in the middle of SCL high
  task automatic bit_xfer(input logic b, input logic gl, output logic r);
    host_low = ~b;
    wait_q();
    scl_r = 1'b1;
    wait_q();
    if (gl) begin
      host_low = ~host_low;
      @(negedge clk);
      host_low = ~host_low;
    end
    r = sda_bus;
    wait_q();
    scl_r = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    host_low = 1'b0;
    wait_q();
    scl_r = 1'b1;
    wait_q();
    host_low = 1'b1;
    wait_q();
    scl_r = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    host_low = 1'b1;
    wait_q();
    scl_r = 1'b1;
    wait_q();
    host_low = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input int gpos, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], (i == gpos), r);
    bit_xfer(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, 1'b0, r);
      d = {d[6:0], r};
    end
    bit_xfer(~ack, 1'b0, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;

    repeat (5) @(negedge clk);
    check("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("rst_csr_a", {27'd0, bus.csr_a}, 32'd0);
    check("rst_csr_di", {24'd0, bus.csr_di}, 32'd0);
    check("rst_csr_we", {31'd0, bus.csr_we}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single write: reg 0x00 <= 0x41
    i2c_start();
    write_byte(8'h94, -1, ack); check("wr_ack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h00, -1, ack); check("wr_ack_reg", {31'd0, ack}, 32'd1);
    write_byte(8'h41, -1, ack); check("wr_ack_data", {31'd0, ack}, 32'd1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("wr_count", we_a.size(), 32'd1);
    check("wr_a", qa(0), 32'h00);
    check("wr_di", qd(0), 32'h41);
    check("wr_oe_after_stop", {31'd0, bus.sda_oe}, 32'd0);
    check("wr_ptr_inc", {27'd0, bus.csr_a}, 32'h01);
    we_a.delete(); we_d.delete();

    // Burst write wrapping 0x1f -> 0x00
    i2c_start();
    write_byte(8'h94, -1, ack);
    write_byte(8'h1f, -1, ack);
    write_byte(8'haa, -1, ack); check("burst_ack0", {31'd0, ack}, 32'd1);
    write_byte(8'h55, -1, ack); check("burst_ack1", {31'd0, ack}, 32'd1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("burst_count", we_a.size(), 32'd2);
    check("burst_a0", qa(0), 32'h1f);
    check("burst_d0", qd(0), 32'haa);
    check("burst_a1", qa(1), 32'h00);
    check("burst_d1", qd(1), 32'h55);
    check("burst_ptr", {27'd0, bus.csr_a}, 32'h01);
    we_a.delete(); we_d.delete();

    // Combined read from reg 0x03 with repeated START
    i2c_start();
    write_byte(8'h94, -1, ack);
    write_byte(8'h03, -1, ack);
    i2c_start();
    write_byte(8'h95, -1, ack); check("rd_ack_addr", {31'd0, ack}, 32'd1);
    read_byte(1'b1, d); check("rd_byte0", {24'd0, d}, 32'h13);
    read_byte(1'b0, d); check("rd_byte1", {24'd0, d}, 32'h14);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("rd_no_write", we_a.size(), 32'd0);
    check("rd_oe_released", {31'd0, bus.sda_oe}, 32'd0);

    // Address mismatch: never drives SDA, never writes
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'ha0, -1, ack); check("mm_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h00, -1, ack);
    write_byte(8'h77, -1, ack);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("mm_oe_seen", {31'd0, oe_seen}, 32'd0);
    check("mm_no_write", we_a.size(), 32'd0);

    // 1-clk SDA glitches while SCL high are neither START nor STOP
    i2c_start();
    write_byte(8'h94, -1, ack);
    write_byte(8'h06, -1, ack);
    write_byte(8'hff, 7, ack); check("gl_ack0", {31'd0, ack}, 32'd1);
    write_byte(8'h00, 3, ack); check("gl_ack1", {31'd0, ack}, 32'd1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("gl_count", we_a.size(), 32'd2);
    check("gl_a0", qa(0), 32'h06);
    check("gl_d0", qd(0), 32'hff);
    check("gl_a1", qa(1), 32'h07);
    check("gl_d1", qd(1), 32'h00);
    we_a.delete(); we_d.delete();

    // STOP after 4 data bits: pointer set, no write, back to IDLE
    i2c_start();
    write_byte(8'h94, -1, ack);
    write_byte(8'h08, -1, ack);
    bit_xfer(1'b1, 1'b0, r);
    bit_xfer(1'b0, 1'b0, r);
    bit_xfer(1'b1, 1'b0, r);
    bit_xfer(1'b0, 1'b0, r);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("ab_no_write", we_a.size(), 32'd0);
    check("ab_ptr", {27'd0, bus.csr_a}, 32'h08);
    check("ab_oe", {31'd0, bus.sda_oe}, 32'd0);
    write_byte(8'h94, -1, ack); check("ab_idle_no_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    repeat (10) @(negedge clk);

`ifdef I2C_CSR_TIMEOUT_EN
    // SCL held low during the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h94 >> i) & 8'h01) != 8'h00, 1'b0, r);
    host_low = 1'b0;
    repeat (82) @(negedge clk);
    check("to_oe_before", {31'd0, bus.sda_oe}, 32'd1);
    repeat (30) @(negedge clk);
    check("to_oe_after", {31'd0, bus.sda_oe}, 32'd0);
    i2c_start();
    write_byte(8'h94, -1, ack); check("to_next_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    repeat (10) @(negedge clk);
`endif

    // Asynchronous reset while driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h94 >> i) & 8'h01) != 8'h00, 1'b0, r);
    host_low = 1'b0;
    check("ar_oe_pre", {31'd0, bus.sda_oe}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("ar_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("ar_csr_a", {27'd0, bus.csr_a}, 32'd0);
    check("ar_csr_we", {31'd0, bus.csr_we}, 32'd0);
    scl_r = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    check("we_width", we_long, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
